// File: rtl/counter_bank.sv
// counter_bank: CHANNELS programmable up/down/LFSR counters behind a
// wishbone slave, with logic-analyzer freeze, load and readback.
module counter_bank #(
  parameter int unsigned BITS      = 32,
  parameter int unsigned CHANNELS  = 4,
  parameter logic [31:0] LFSR_POLY = 32'hA3000000
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  input  logic                       wbs_cyc_i,
  input  logic                       wbs_stb_i,
  input  logic                       wbs_we_i,
  input  logic [3:0]                 wbs_sel_i,
  input  logic [31:0]                wbs_adr_i,
  input  logic [31:0]                wbs_dat_i,
  output logic                       wbs_ack_o,
  output logic [31:0]                wbs_dat_o,
  input  logic [63:0]                la_data_in,
  input  logic [63:0]                la_oenb,
  output logic [63:0]                la_data_out,
  output logic [CHANNELS*BITS-1:0]   count_o,
  output logic [2:0]                 irq
);

  typedef logic [BITS-1:0] word_t;

  localparam word_t POLY = LFSR_POLY[BITS-1:0];

  localparam logic [1:0] M_UP   = 2'b00;
  localparam logic [1:0] M_DN   = 2'b01;
  localparam logic [1:0] M_LFSR = 2'b10;

  localparam logic [1:0] R_CTRL = 2'd0;
  localparam logic [1:0] R_CNT  = 2'd1;
  localparam logic [1:0] R_RLD  = 2'd2;
  localparam logic [1:0] R_STS  = 2'd3;

  logic        valid;
  logic        fire;
  logic        wr;
  logic [1:0]  sel_ch;
  logic [1:0]  sel_reg;
  logic [31:0] wmask;
  word_t       bmask;
  word_t       wdat;

  assign valid   = wbs_cyc_i & wbs_stb_i;
  assign fire    = valid & ~wbs_ack_o;
  assign wr      = fire & wbs_we_i;
  assign sel_ch  = wbs_adr_i[5:4];
  assign sel_reg = wbs_adr_i[3:2];
  assign bmask   = wmask[BITS-1:0];
  assign wdat    = wbs_dat_i[BITS-1:0];

  always_comb begin
    wmask = '0;
    for (int b = 0; b < 4; b++) begin
      wmask[8*b +: 8] = {8{wbs_sel_i[b]}};
    end
  end

  logic        frz;
  logic        ld;
  logic [1:0]  ld_ch;
  word_t       ld_val;

  assign frz    = la_data_in[0] & ~la_oenb[0];
  assign ld     = la_data_in[3] & ~la_oenb[3];
  assign ld_ch  = la_data_in[2:1];
  assign ld_val = la_data_in[32 +: BITS];

  word_t               cnt [CHANNELS];
  word_t               rld [CHANNELS];
  logic [4:0]          ctl [CHANNELS];
  logic [CHANNELS-1:0] tc;
  logic [CHANNELS-1:0] ien;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    word_t      cnt_q;
    word_t      rld_q;
    logic [4:0] ctl_q;
    logic       tc_q;
    logic       hit;
    logic       hit_ctl;
    logic       hit_cnt;
    logic       hit_rld;
    logic       hit_sts;
    logic       hit_ld;
    logic       run;
    logic       term;
    logic       tc_set;
    logic       oneshot;
    word_t      step;

    assign hit = wr && (sel_ch == 2'(c));

    always_comb begin
      hit_ctl = 1'b0;
      hit_cnt = 1'b0;
      hit_rld = 1'b0;
      hit_sts = 1'b0;
      unique case (1'b1)
        (sel_reg == R_CTRL): hit_ctl = hit;
        (sel_reg == R_CNT):  hit_cnt = hit;
        (sel_reg == R_RLD):  hit_rld = hit;
        (sel_reg == R_STS):  hit_sts = hit;
        default: ;
      endcase
    end

    assign hit_ld = ld && (ld_ch == 2'(c));

    always_comb begin
      step = cnt_q;
      term = 1'b0;
      case (ctl_q[2:1])
        M_UP: begin
          term = (cnt_q == rld_q);
          step = term ? '0 : cnt_q + word_t'(1);
        end
        M_DN: begin
          term = (cnt_q == '0);
          step = term ? rld_q : cnt_q - word_t'(1);
        end
        M_LFSR: begin
          term = (cnt_q == rld_q);
          if (cnt_q == '0) step = word_t'(1);
          else step = (cnt_q >> 1) ^ (cnt_q[0] ? POLY : '0);
        end
        default: ;
      endcase
    end

    // a load or write landing on COUNT pre-empts this cycle's step and TC
    assign run     = ctl_q[0] & ~frz & ~hit_ld & ~hit_cnt;
    assign tc_set  = run & term;
    assign oneshot = tc_set & ~ctl_q[4] & ~ctl_q[2];

    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
        cnt_q <= '0;
        rld_q <= '1;
        ctl_q <= '0;
        tc_q  <= 1'b0;
      end else begin
        if (hit_ld) cnt_q <= ld_val;
        else if (hit_cnt) cnt_q <= (cnt_q & ~bmask) | (wdat & bmask);
        else if (run) cnt_q <= step;

        if (hit_rld) rld_q <= (rld_q & ~bmask) | (wdat & bmask);

        if (hit_ctl && wbs_sel_i[0]) ctl_q <= wbs_dat_i[4:0];
        else if (oneshot) ctl_q[0] <= 1'b0;

        if (tc_set) tc_q <= 1'b1;
        else if (hit_sts && wbs_sel_i[0] && wbs_dat_i[0]) tc_q <= 1'b0;
      end
    end

    assign cnt[c] = cnt_q;
    assign rld[c] = rld_q;
    assign ctl[c] = ctl_q;
    assign tc[c]  = tc_q;
    assign ien[c] = ctl_q[3];
    assign count_o[c*BITS +: BITS] = cnt_q;
  end

  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (sel_ch == 2'(c)) begin
        case (sel_reg)
          R_CTRL:  rdata = 32'(ctl[c]);
          R_CNT:   rdata = 32'(cnt[c]);
          R_RLD:   rdata = 32'(rld[c]);
          default: rdata = {31'b0, tc[c]};
        endcase
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      wbs_ack_o <= fire;
      if (fire) wbs_dat_o <= rdata;
    end
  end

  always_comb begin
    la_data_out = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (la_data_in[2:1] == 2'(c)) la_data_out[31:0] = 32'(cnt[c]);
    end
    la_data_out[32 +: CHANNELS] = tc;
  end

  assign irq = {2'b00, |(tc & ien)};

  logic unused;
  assign unused = ^{wbs_adr_i, la_data_in, la_oenb, wbs_dat_i};

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: directed checks of counter_bank register access,
// counting modes, collisions, LA freeze/load/readback and reset.
module tb_counter_bank;

  logic         clk = 1'b0;
  logic         rst;
  logic         cyc, stb, we;
  logic [3:0]   sel;
  logic [31:0]  adr, dat;
  logic         ack;
  logic [31:0]  rdat;
  logic [63:0]  la_in, la_oenb, la_out;
  logic [127:0] cnt;
  logic [2:0]   irq;

  logic         s_ack;
  logic [31:0]  s_rdat;
  logic [63:0]  s_la_out;
  logic [7:0]   s_cnt;
  logic [2:0]   s_irq;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rd, srd;
  logic        ak;

  always #5 clk = ~clk;

  counter_bank u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .la_data_in(la_in), .la_oenb(la_oenb), .la_data_out(la_out),
    .count_o(cnt), .irq(irq)
  );

  counter_bank #(.BITS(8), .CHANNELS(1), .LFSR_POLY(32'h000000B8)) u_small (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
    .wbs_ack_o(s_ack), .wbs_dat_o(s_rdat),
    .la_data_in(la_in), .la_oenb(la_oenb), .la_data_out(s_la_out),
    .count_o(s_cnt), .irq(s_irq)
  );

  task automatic wb(input logic w, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] s,
                    output logic [31:0] r, output logic [31:0] sr,
                    output logic k);
    if (ack) begin
      @(posedge clk); #1;
    end
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; dat = d; sel = s;
    @(posedge clk); #1;
    r = rdat; sr = s_rdat; k = ack;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    logic [31:0] se;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%h exp=0", ack); end
    checks++; if (rdat !== 32'h0) begin failures++; $display("FAIL rst_dat got=%h exp=0", rdat); end
    checks++; if (irq !== 3'b0) begin failures++; $display("FAIL rst_irq got=%h exp=0", irq); end
    checks++; if (la_out !== 64'h0) begin failures++; $display("FAIL rst_la got=%h exp=0", la_out); end
    checks++; if (cnt !== 128'h0) begin failures++; $display("FAIL rst_cnt got=%h exp=0", cnt); end
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      wb(1'b0, 32'(i*4), 32'h0, 4'hF, rd, srd, ak);
      e  = (i % 4 == 2) ? 32'hFFFF_FFFF : 32'h0;
      se = (i == 2) ? 32'h0000_00FF : 32'h0;
      checks++; if (ak !== 1'b1) begin failures++; $display("FAIL rd_ack[%0d] got=%h exp=1", i, ak); end
      checks++; if (rd !== e) begin failures++; $display("FAIL rd_reg[%0d] got=%h exp=%h", i, rd, e); end
      checks++; if (srd !== se) begin failures++; $display("FAIL small_rd[%0d] got=%h exp=%h", i, srd, se); end
    end
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h8;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++; if (ack !== 1'((i + 1) % 2)) begin failures++; $display("FAIL held_ack[%0d] got=%h exp=%h", i, ack, 1'((i + 1) % 2)); end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_up_oneshot;
    logic [31:0] e [5] = '{32'd1, 32'd2, 32'd3, 32'd0, 32'd0};
    logic        t [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    wb(1'b1, 32'h08, 32'd3, 4'hF, rd, srd, ak);
    wb(1'b1, 32'h00, 32'h01, 4'hF, rd, srd, ak);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (cnt[31:0] !== e[i]) begin failures++; $display("FAIL up_cnt[%0d] got=%h exp=%h", i, cnt[31:0], e[i]); end
      checks++; if (la_out[32] !== t[i]) begin failures++; $display("FAIL up_tc[%0d] got=%h exp=%h", i, la_out[32], t[i]); end
    end
    checks++; if (irq !== 3'b000) begin failures++; $display("FAIL up_irq_off got=%h exp=0", irq); end
    wb(1'b0, 32'h00, 32'h0, 4'hF, rd, srd, ak);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL up_en_clr got=%h exp=0", rd); end
    wb(1'b1, 32'h00, 32'h08, 4'hF, rd, srd, ak);
    checks++; if (irq !== 3'b001) begin failures++; $display("FAIL up_irq_on got=%h exp=1", irq); end
    wb(1'b0, 32'h0C, 32'h0, 4'hF, rd, srd, ak);
    checks++; if (rd !== 32'h1) begin failures++; $display("FAIL up_sts got=%h exp=1", rd); end
    wb(1'b1, 32'h0C, 32'h1, 4'hF, rd, srd, ak);
    checks++; if (la_out[32] !== 1'b0) begin failures++; $display("FAIL up_w1c got=%h exp=0", la_out[32]); end
    checks++; if (irq !== 3'b000) begin failures++; $display("FAIL up_w1c_irq got=%h exp=0", irq); end
  endtask

  task automatic test_down_auto;
    logic [31:0] e [10] = '{32'd1, 32'd0, 32'd5, 32'd4, 32'd3,
                            32'd2, 32'd1, 32'd0, 32'd5, 32'd4};
    wb(1'b1, 32'h18, 32'd5, 4'hF, rd, srd, ak);
    wb(1'b1, 32'h14, 32'd2, 4'hF, rd, srd, ak);
    wb(1'b1, 32'h10, 32'h13, 4'hF, rd, srd, ak);
    for (int i = 0; i < 9; i++) begin
      if (i == 3) wb(1'b1, 32'h1C, 32'h1, 4'hF, rd, srd, ak);
      else begin
        @(posedge clk); #1;
      end
      checks++; if (cnt[63:32] !== e[i]) begin failures++; $display("FAIL dn_cnt[%0d] got=%h exp=%h", i, cnt[63:32], e[i]); end
      checks++; if (la_out[33] !== 1'(i == 2 || i == 8)) begin failures++; $display("FAIL dn_tc[%0d] got=%h exp=%h", i, la_out[33], 1'(i == 2 || i == 8)); end
    end
    wb(1'b1, 32'h10, 32'h0, 4'hF, rd, srd, ak);
    checks++; if (cnt[63:32] !== e[9]) begin failures++; $display("FAIL dn_stop got=%h exp=%h", cnt[63:32], e[9]); end
  endtask

  task automatic test_lfsr;
    logic [31:0] e [3] = '{32'h1, 32'hA300_0000, 32'h5180_0000};
    logic        early;
    wb(1'b1, 32'h20, 32'h05, 4'hF, rd, srd, ak);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (cnt[95:64] !== e[i]) begin failures++; $display("FAIL lfsr32[%0d] got=%h exp=%h", i, cnt[95:64], e[i]); end
    end
    wb(1'b1, 32'h20, 32'h0, 4'hF, rd, srd, ak);
    checks++; if (cnt[95:64] !== 32'h28C0_0000) begin failures++; $display("FAIL lfsr32_stop got=%h exp=28c00000", cnt[95:64]); end
    wb(1'b1, 32'h00, 32'h05, 4'hF, rd, srd, ak);
    @(posedge clk); #1;
    checks++; if (s_cnt !== 8'h01) begin failures++; $display("FAIL lfsr8_escape got=%h exp=01", s_cnt); end
    early = 1'b0;
    for (int i = 2; i < 256; i++) begin
      @(posedge clk); #1;
      if (i < 256 && i != 255 + 1 && s_cnt === 8'h01 && i < 255 + 1) early = (i != 256) ? (early | (i <= 255)) : early;
    end
    checks++; if (early !== 1'b0) begin failures++; $display("FAIL lfsr8_period got=early exp=255"); end
    @(posedge clk); #1;
    checks++; if (s_cnt !== 8'h01) begin failures++; $display("FAIL lfsr8_wrap got=%h exp=01", s_cnt); end
    wb(1'b1, 32'h00, 32'h0, 4'hF, rd, srd, ak);
    wb(1'b1, 32'h04, 32'h0, 4'hF, rd, srd, ak);
    checks++; if (s_cnt !== 8'h00 || cnt[31:0] !== 32'h0) begin failures++; $display("FAIL lfsr_clear got=%h/%h exp=0", s_cnt, cnt[31:0]); end
  endtask

  task automatic test_collision;
    wb(1'b1, 32'h34, 32'h1234_5600, 4'hF, rd, srd, ak);
    wb(1'b1, 32'h30, 32'h01, 4'hF, rd, srd, ak);
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      checks++; if (cnt[127:96] !== 32'h1234_5600 + 32'(i)) begin failures++; $display("FAIL col_run[%0d] got=%h exp=%h", i, cnt[127:96], 32'h1234_5600 + 32'(i)); end
    end
    wb(1'b1, 32'h34, 32'h0000_00AA, 4'b0001, rd, srd, ak);
    checks++; if (cnt[127:96] !== 32'h1234_56AA) begin failures++; $display("FAIL col_byte got=%h exp=123456aa", cnt[127:96]); end
    @(posedge clk); #1;
    checks++; if (cnt[127:96] !== 32'h1234_56AB) begin failures++; $display("FAIL col_resume got=%h exp=123456ab", cnt[127:96]); end
    la_in[3] = 1'b1; la_in[2:1] = 2'd3; la_in[63:32] = 32'h0BAD_F00D;
    la_oenb[3] = 1'b0;
    wb(1'b1, 32'h34, 32'h0000_0055, 4'hF, rd, srd, ak);
    la_in[3] = 1'b0; la_oenb[3] = 1'b1;
    checks++; if (cnt[127:96] !== 32'h0BAD_F00D) begin failures++; $display("FAIL col_la got=%h exp=0badf00d", cnt[127:96]); end
    checks++; if (s_cnt !== 8'h00) begin failures++; $display("FAIL col_small got=%h exp=00", s_cnt); end
    @(posedge clk); #1;
    checks++; if (cnt[127:96] !== 32'h0BAD_F00E) begin failures++; $display("FAIL col_la_run got=%h exp=0badf00e", cnt[127:96]); end
    wb(1'b1, 32'h30, 32'h0, 4'hF, rd, srd, ak);
    checks++; if (cnt[127:96] !== 32'h0BAD_F00F) begin failures++; $display("FAIL col_stop got=%h exp=0badf00f", cnt[127:96]); end
  endtask

  task automatic test_freeze;
    logic [31:0] e [4] = '{32'h0, 32'h4, 32'h28C0_0000, 32'h0BAD_F00F};
    la_in[0] = 1'b1; la_oenb[0] = 1'b0;
    wb(1'b1, 32'h30, 32'h11, 4'hF, rd, srd, ak);
    wb(1'b1, 32'h10, 32'h13, 4'hF, rd, srd, ak);
    wb(1'b0, 32'h34, 32'h0, 4'hF, rd, srd, ak);
    checks++; if (rd !== 32'h0BAD_F00F) begin failures++; $display("FAIL frz_read got=%h exp=0badf00f", rd); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (cnt[127:32] !== {e[3], e[2], e[1]}) begin failures++; $display("FAIL frz_hold[%0d] got=%h", i, cnt[127:32]); end
    end
    for (int s = 0; s < 4; s++) begin
      la_in[2:1] = 2'(s);
      #1;
      checks++; if (la_out[31:0] !== e[s]) begin failures++; $display("FAIL la_sel[%0d] got=%h exp=%h", s, la_out[31:0], e[s]); end
    end
    checks++; if (la_out[63:33] !== 31'h1) begin failures++; $display("FAIL la_tc got=%h exp=1", la_out[63:33]); end
    la_in[0] = 1'b0; la_oenb[0] = 1'b1; la_in[2:1] = 2'd0;
    @(posedge clk); #1;
    checks++; if (cnt[127:96] !== 32'h0BAD_F010) begin failures++; $display("FAIL frz_rel3 got=%h exp=0badf010", cnt[127:96]); end
    checks++; if (cnt[63:32] !== 32'h3) begin failures++; $display("FAIL frz_rel1 got=%h exp=3", cnt[63:32]); end
  endtask

  task automatic test_reset_mid_write;
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    adr = 32'h28; dat = 32'h0000_DEAD; sel = 4'hF;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rmw_ack got=%h exp=0", ack); end
    checks++; if (cnt !== 128'h0) begin failures++; $display("FAIL rmw_cnt got=%h exp=0", cnt); end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL rmw_ack2 got=%h exp=0", ack); end
    wb(1'b0, 32'h28, 32'h0, 4'hF, rd, srd, ak);
    checks++; if (rd !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rmw_rld got=%h exp=ffffffff", rd); end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; adr = 32'h0; dat = 32'h0;
    la_in = 64'h0; la_oenb = '1;
    test_reset;
    test_up_oneshot;
    test_down_auto;
    test_lfsr;
    test_collision;
    test_freeze;
    test_reset_mid_write;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/counter_bank.md
# counter_bank

Multi-channel programmable counter/PRBS generator: the parametrised successor to the single wishbone counter in the user project. Provides CHANNELS independent BITS-wide counters, each selectable as up-counter, down-counter, Galois LFSR, or hold. Each channel has a reload/compare register, a sticky terminal-count flag and an interrupt. Sits in the user area behind the wishbone slave (WB MI A); logic-analyzer probes give freeze, load and readback control, and count values go to the IO pads.

## Interface
- BITS, 32: counter width per channel, 8..32.
- CHANNELS, 4: channel count, 1..4.
- LFSR_POLY, 32'hA3000000: Galois feedback taps; only the low BITS bits are used.

Ports:
- wb_clk_i  in  1  sole clock; all state changes on its rising edge
- wb_rst_i  in  1  reset, synchronous, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  wishbone cycle, strobe, write enable
- wbs_sel_i  in  4  byte lanes
- wbs_adr_i  in  32  byte address; only adr[5:2] decoded
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- la_data_in, la_oenb  in  64 each  LA probes; a probe is active when its oenb bit is 0
- la_data_out  out  64  LA readback
- count_o  out  CHANNELS*BITS  all counts; channel c at [c*BITS +: BITS]
- irq  out  3  irq[0] = OR over c of (TC[c] & IRQ_EN[c]); irq[2:1] = 0

## Operation
- Register map: adr[5:4] = channel, adr[3:2] = register.
  - 0x0 CTRL: [0] EN; [2:1] MODE (00 up, 01 down, 10 LFSR, 11 hold); [3] IRQ_EN; [4] AUTO.
  - 0x4 COUNT.
  - 0x8 RELOAD.
  - 0xC STATUS: [0] TC, write-1-to-clear.
- Registers narrower than 32 bits read zero-extended. Channels ≥ CHANNELS read 0 and ignore writes.
- Writes honour wbs_sel_i per byte.
- Each cycle with EN=1 and no freeze, per channel:
  - Up: if COUNT==RELOAD, COUNT←0 and TC←1, and EN←0 when AUTO=0 (one-shot). Otherwise COUNT+1.
  - Down: if COUNT==0, COUNT←RELOAD and TC←1, and EN←0 when AUTO=0. Otherwise COUNT−1.
  - LFSR: COUNT←(COUNT>>1) ^ (COUNT[0] ? LFSR_POLY : 0). A COUNT of 0 loads 1 (lock-up escape). TC←1 when the pre-shift COUNT==RELOAD. Never self-disables.
  - Hold, or EN=0: COUNT unchanged.
- Freeze: la_data_in[0] with la_oenb[0]=0 holds every channel (the enable term is forced false). Register access still works.
- LA load: la_data_in[3] with la_oenb[3]=0 loads channel la_data_in[2:1] with la_data_in[32 +: BITS] that cycle.
- la_data_out:
  - [31:0] = COUNT of the channel selected by la_data_in[2:1], zero-extended.
  - [32+c] = TC[c].
  - All other bits 0.
- Priority on one channel's COUNT, highest first: reset, LA load, wishbone write (only written bytes take new data; unwritten bytes keep the pre-update value), counting. Counting and TC evaluation are suppressed in any cycle where a load or write hits that channel's COUNT.
- TC set and a W1C in the same cycle: set wins.
- A CTRL write in the same cycle as a one-shot EN clear: the written EN value wins.

## Timing
- Reset values:
  - COUNT=0, CTRL=0, RELOAD=all ones, TC=0.
  - wbs_ack_o=0, wbs_dat_o=0, irq=0, la_data_out=0.
- Wishbone:
  - valid = cyc & stb.
  - wbs_ack_o rises the cycle after valid is seen with ack low, and is high for exactly 1 cycle.
  - A continuously held request acks every other cycle.
- Write commits on the ack edge.
- Read data is registered: wbs_dat_o is valid while ack=1 and reflects state before that edge's updates. wbs_dat_o holds its value otherwise.
- Counting latency: COUNT changes at the first edge after EN=1 is written, so 1 count per clock thereafter.
- TC and irq are registered and assert on the same edge as the terminal transition.
- Reset asserted mid-transaction: ack drops next edge, the transfer is abandoned, and no write commits.

## Test plan
- Reset, then read all 16 addresses → CTRL/COUNT/STATUS = 0, RELOAD = 0xFFFFFFFF; ack on every 2nd cycle of a held request.
- Ch0: RELOAD=3, CTRL=0x01 (up, one-shot) → COUNT 1,2,3,0 then stops. TC=1, irq[0]=0. Set IRQ_EN → irq[0]=1. W1C STATUS → TC=0, irq[0]=0.
- Ch1: RELOAD=5, CTRL=0x13 (down, auto), COUNT=2 → 1,0,5,4,… with TC set on each 0→5 transition.
- Ch2: LFSR mode, COUNT=0 → next value 1; run 255 cycles with BITS=8, POLY=0xB8 → sequence returns to 1 (maximal length).
- Ch3 running up: write COUNT with sel=4'b0001, data 0xAA in the same cycle as an increment → byte0 = 0xAA, bytes 3:1 unchanged, no increment. An LA load colliding with that write → LA value wins.
- Freeze via la_data_in[0] for 10 cycles → all counts static. la_data_out[31:0] tracks the channel selected by la_data_in[2:1]. Reset mid-write → no ack, no commit.
